// File: rtl/oam_dma_ctrl.sv
// Sprite DMA engine: a CPU write to DMA_REG_ADDR halts the CPU and copies one
// 256-byte page from CPU space into OAM, advancing only on CPU-cycle enables.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_ce,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_data_in,
  input  logic [7:0]  oam_start,
  output logic        cpu_rdy,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data_in,
  output logic        oam_dma,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data_out,
  output logic        oam_we
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] base_q, base_d;
  logic [7:0] idx_q, idx_d;
  logic       parity_q, parity_d;
  logic       trigger_s;

  assign trigger_s = cpu_we && (cpu_addr == DMA_REG_ADDR);

  // State, counter and parity registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      page_q   <= 8'h00;
      base_q   <= 8'h00;
      idx_q    <= 8'h00;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      base_q   <= base_d;
      idx_q    <= idx_d;
      parity_q <= parity_d;
    end
  end

  // Next-state logic; everything holds while cpu_ce is low
  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    base_d   = base_q;
    idx_d    = idx_q;
    parity_d = parity_q;
    if (cpu_ce) begin
      parity_d = ~parity_q;
      case (state_q)
        S_IDLE: begin
          if (trigger_s) begin
            page_d  = cpu_data_in;
            base_d  = oam_start;
            idx_d   = 8'h00;
            state_d = S_HALT;
          end else begin
            state_d = S_IDLE;
          end
        end
        // An odd-parity halt cycle needs one extra alignment cycle
        S_HALT: begin
          if (parity_q) begin
            state_d = S_ALIGN;
          end else begin
            state_d = S_READ;
          end
        end
        S_ALIGN: state_d = S_READ;
        S_READ:  state_d = S_WRITE;
        S_WRITE: begin
          if (idx_q == 8'hFF) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 8'h01;
            state_d = S_READ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output decode from the registered state and counters
  always_comb begin
    cpu_rdy      = (state_q == S_IDLE);
    oam_dma      = (state_q != S_IDLE);
    mem_rd       = 1'b0;
    mem_addr     = 16'h0000;
    oam_addr     = 8'h00;
    oam_data_out = 8'h00;
    oam_we       = 1'b0;
    case (state_q)
      S_READ: begin
        mem_rd   = 1'b1;
        mem_addr = {page_q, idx_q};
      end
      S_WRITE: begin
        oam_addr     = base_q + idx_q;
        oam_data_out = mem_data_in;
        oam_we       = cpu_ce;
      end
      default: begin
        mem_rd = 1'b0;
        oam_we = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized bench for oam_dma_ctrl: a page-copy reference model predicts OAM
// contents, write order, read addresses and halt length for each transfer.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_ce = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_data_in = 8'h00;
  logic [7:0]  oam_start = 8'h00;
  logic        cpu_rdy;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data_in = 8'h00;
  logic        oam_dma;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data_out;
  logic        oam_we;

  oam_dma_ctrl #(.DMA_REG_ADDR(16'h4014)) dut (
    .clk(clk), .reset(reset), .cpu_ce(cpu_ce), .cpu_addr(cpu_addr),
    .cpu_we(cpu_we), .cpu_data_in(cpu_data_in), .oam_start(oam_start),
    .cpu_rdy(cpu_rdy), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_data_in(mem_data_in), .oam_dma(oam_dma), .oam_addr(oam_addr),
    .oam_data_out(oam_data_out), .oam_we(oam_we)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // cpu_ce pattern: 0 = always, 1 = one in three, 2 = random
  int ce_mode = 0;
  int phase = 0;
  always @(posedge clk) begin
    #1;
    case (ce_mode)
      0: cpu_ce = 1'b1;
      1: begin
        phase = (phase + 1) % 3;
        cpu_ce = (phase == 0);
      end
      default: cpu_ce = ($urandom_range(0, 3) != 0);
    endcase
  end

  logic [7:0] mem [0:65535];
  logic [7:0] oam [0:255];

  // CPU-space memory: data appears on the ce cycle after the read and then holds
  always @(posedge clk) if (cpu_ce && mem_rd) mem_data_in <= mem[mem_addr];

  int unsigned ce_count;
  always @(posedge clk or negedge reset)
    if (!reset) ce_count <= 0;
    else if (cpu_ce) ce_count <= ce_count + 1;

  logic [7:0]  wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  logic [15:0] rd_q[$];
  int low_clk, low_ce, we_viol, dma_bad;

  // OAM sink and bus observer, sampled mid-cycle
  always @(negedge clk) if (reset) begin
    if (oam_we) begin
      wr_addr_q.push_back(oam_addr);
      wr_data_q.push_back(oam_data_out);
      oam[oam_addr] = oam_data_out;
      if (!cpu_ce) we_viol++;
    end
    if (mem_rd && cpu_ce) rd_q.push_back(mem_addr);
    if (!cpu_rdy) begin
      low_clk++;
      if (cpu_ce) low_ce++;
    end
    if (oam_dma === cpu_rdy) dma_bad++;
  end

  logic [7:0] cur_page, cur_base;
  int         cur_align;

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input logic we,
                           output int unsigned prior, output logic rdy_after);
    @(negedge clk);
    cpu_addr = a; cpu_data_in = d; cpu_we = we;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk);
      if (cpu_ce) break;
    end
    prior = ce_count;
    #1 rdy_after = cpu_rdy;
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = 16'h0000;
  endtask

  task automatic start_dma(input logic [7:0] page, input logic [7:0] base, input int want_align);
    int unsigned prior;
    logic rdy_after;
    if (ce_mode == 0 && want_align >= 0) begin
      @(negedge clk);
      if (int'(ce_count % 2) != want_align) @(negedge clk);
    end
    cur_page = page; cur_base = base;
    for (int i = 0; i < 256; i++) oam[i] = 8'hxx;
    wr_addr_q.delete(); wr_data_q.delete(); rd_q.delete();
    low_clk = 0; low_ce = 0; we_viol = 0; dma_bad = 0;
    oam_start = base;
    cpu_write(16'h4014, page, 1'b1, prior, rdy_after);
    cur_align = int'((prior + 1) % 2);
    n_vec++;
    if (rdy_after !== 1'b0) begin
      n_err++; $display("FAIL rdy_fall: cpu_rdy=%b after trigger, want 0", rdy_after);
    end
  endtask

  task automatic finish_dma(input string name);
    bit done = 0;
    int bad_w = 0, bad_r = 0, bad_o = 0, exp_low;
    for (int t = 0; t < 8000; t++) begin
      @(negedge clk);
      if (cpu_rdy) begin done = 1; break; end
    end
    n_vec++;
    if (!done) begin n_err++; $display("FAIL %s done: transfer did not finish", name); end
    exp_low = 513 + cur_align;
    n_vec++;
    if (low_ce !== exp_low) begin
      n_err++; $display("FAIL %s halt_len: got %0d ce cycles, want %0d", name, low_ce, exp_low);
    end
    if (ce_mode == 1) begin
      n_vec++;
      if (low_clk > 3 * exp_low + 2 || low_clk < 3 * exp_low - 2) begin
        n_err++; $display("FAIL %s halt_clk: got %0d clk, want %0d +-2", name, low_clk, 3 * exp_low);
      end
    end
    n_vec++;
    if (wr_addr_q.size() !== 256) begin
      n_err++; $display("FAIL %s wr_count: got %0d, want 256", name, wr_addr_q.size());
    end
    for (int k = 0; k < 256; k++) begin
      logic [7:0]  ea;
      logic [15:0] ra;
      ea = cur_base + k[7:0];
      ra = {cur_page, k[7:0]};
      if (k < wr_addr_q.size())
        if (wr_addr_q[k] !== ea || wr_data_q[k] !== mem[ra]) bad_w++;
      if (k < rd_q.size()) begin
        if (rd_q[k] !== ra) bad_r++;
      end else bad_r++;
      if (oam[ea] !== mem[ra]) bad_o++;
    end
    n_vec++;
    if (bad_w !== 0) begin n_err++; $display("FAIL %s wr_seq: %0d bad writes, want 0", name, bad_w); end
    n_vec++;
    if (bad_r !== 0) begin n_err++; $display("FAIL %s rd_seq: %0d bad reads, want 0", name, bad_r); end
    n_vec++;
    if (bad_o !== 0) begin n_err++; $display("FAIL %s oam: %0d bad bytes, want 0", name, bad_o); end
    n_vec++;
    if (we_viol !== 0 || dma_bad !== 0) begin
      n_err++; $display("FAIL %s strobes: we_off_ce=%0d dma_bad=%0d, want 0 0", name, we_viol, dma_bad);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if ({cpu_rdy, oam_dma, mem_rd, oam_we} !== 4'b1000) begin
      n_err++; $display("FAIL reset_ctl: got %b, want 1000", {cpu_rdy, oam_dma, mem_rd, oam_we});
    end
    n_vec++;
    if ({mem_addr, oam_addr, oam_data_out} !== 32'h0) begin
      n_err++; $display("FAIL reset_bus: got %h, want 0", {mem_addr, oam_addr, oam_data_out});
    end
    reset = 1'b1;
  endtask

  task automatic test_even();
    ce_mode = 0;
    start_dma(8'h02, 8'h00, 0);
    finish_dma("even");
  endtask

  task automatic test_odd();
    ce_mode = 0;
    start_dma(8'h02, 8'h00, 1);
    finish_dma("odd");
  endtask

  task automatic test_wrap();
    ce_mode = 0;
    start_dma(8'hFF, 8'hF0, -1);
    repeat (20) @(negedge clk);
    oam_start = 8'($urandom);
    finish_dma("wrap");
    n_vec++;
    if (wr_addr_q.size() < 256 || wr_addr_q[0] !== 8'hF0 || wr_data_q[0] !== mem[16'hFF00] ||
        wr_addr_q[16] !== 8'h00 || wr_addr_q[255] !== 8'hEF || wr_data_q[255] !== mem[16'hFFFF]) begin
      n_err++; $display("FAIL wrap_points: first/16th/last write addr or data wrong, want F0/00/EF");
    end
  endtask

  task automatic test_ce_third();
    ce_mode = 1;
    start_dma(8'($urandom), 8'($urandom), -1);
    finish_dma("ce_third");
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    ce_mode = 0;
    start_dma(8'h37, 8'($urandom), -1);
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (oam_we && oam_addr == 8'(cur_base + 8'd100)) begin found = 1; break; end
    end
    n_vec++;
    if (!found) begin n_err++; $display("FAIL rst_mid_reach: write idx 100 not seen"); end
    reset = 1'b0;
    #1;
    n_vec++;
    if ({cpu_rdy, oam_dma, oam_we, mem_rd} !== 4'b1000) begin
      n_err++; $display("FAIL rst_mid: got %b, want 1000", {cpu_rdy, oam_dma, oam_we, mem_rd});
    end
    @(negedge clk);
    reset = 1'b1;
    start_dma(8'h37, 8'($urandom), -1);
    finish_dma("rst_restart");
  endtask

  task automatic test_ignored();
    int unsigned prior;
    logic r1, r2, r3;
    ce_mode = 0;
    low_clk = 0;
    cpu_write(16'h4015, 8'h11, 1'b1, prior, r1);
    cpu_write(16'h4014, 8'h22, 1'b0, prior, r2);
    repeat (5) @(negedge clk);
    n_vec++;
    if ({r1, r2} !== 2'b11 || low_clk !== 0) begin
      n_err++; $display("FAIL no_trigger: rdy=%b%b low_clk=%0d, want 11 0", r1, r2, low_clk);
    end
    start_dma(8'h5C, 8'h00, -1);
    repeat (40) @(negedge clk);
    oam_start = 8'h80;
    cpu_write(16'h4014, 8'hA3, 1'b1, prior, r3);
    finish_dma("busy_retrigger");
  endtask

  task automatic test_back_to_back();
    ce_mode = 2;
    for (int n = 0; n < 3; n++) begin
      start_dma(8'($urandom), 8'($urandom), -1);
      finish_dma("b2b_random");
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
    test_reset();
    test_even();
    test_odd();
    test_wrap();
    test_ce_third();
    test_reset_mid();
    test_ignored();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/oam_dma_ctrl.md
# oam_dma_ctrl

Sprite DMA engine that sits directly upstream of the PPU's OAM write port. A CPU write to $4014 selects a 256-byte source page. The block then halts the CPU, copies the page byte-by-byte from CPU address space into OAM, and releases the CPU. It drives the PPU-side `oam_dma`, `oam_addr` and `oam_data_in` signals, and all of its state advances on CPU-cycle enables.

## Interface

Parameters:
- DMA_REG_ADDR, 16'h4014: CPU address whose write triggers a transfer.

Ports:
- clk  in  1  system clock; the single clock for the block.
- reset  in  1  asynchronous, active-low reset.
- cpu_ce  in  1  CPU-cycle enable; the FSM, counters and parity advance only when high.
- cpu_addr  in  16  CPU bus address.
- cpu_we  in  1  CPU write strobe.
- cpu_data_in  in  8  CPU write data; the page number on a trigger.
- oam_start  in  8  current OAMADDR value, sampled at trigger.
- cpu_rdy  out  1  0 = CPU halted.
- mem_addr  out  16  DMA read address into CPU space.
- mem_rd  out  1  DMA read request.
- mem_data_in  in  8  read data, valid on the cpu_ce cycle after mem_rd.
- oam_dma  out  1  DMA owns the OAM port (to PPU).
- oam_addr  out  8  OAM write address (to PPU).
- oam_data_out  out  8  OAM write data (to PPU oam_data_in).
- oam_we  out  1  OAM write strobe.

## Operation

Trigger:
- A cpu_ce cycle with cpu_we=1, cpu_addr==DMA_REG_ADDR and state IDLE is a trigger.
- On a trigger the block latches page<=cpu_data_in, base<=oam_start and idx<=0, and moves to HALT.
- Triggers in any other state are ignored.

States (transitions occur only on cpu_ce):
- IDLE: waits for a trigger.
- HALT: dummy cycle. Goes to ALIGN if parity==1, otherwise to READ.
- ALIGN: dummy cycle. Goes to READ.
- READ: mem_addr={page,idx}, mem_rd=1. Goes to WRITE.
- WRITE: oam_addr=base+idx (mod 256), oam_data_out=mem_data_in, oam_we=cpu_ce. If idx==8'hFF, go to IDLE; otherwise idx<=idx+1 and go to READ.

Parity:
- A 1-bit register that toggles on every cpu_ce, including cycles in IDLE.
- Reset value is 0.

Output decoding:
- cpu_rdy = (state==IDLE).
- oam_dma = (state!=IDLE).
- Outputs are decoded combinationally from the registered state and counters.

Arithmetic and widths:
- idx is 8 bits; the 256th write terminates the transfer, so there is no idx overflow.
- The oam_addr sum is 8-bit and wraps (base 8'hF0 writes F0..FF, then 00..EF).
- mem_addr never crosses a page: page FF reads FF00..FFFF.

## Timing

Reset:
- Asserting reset (low) at any time, including mid-transfer, forces IDLE immediately.
- Reset values: cpu_rdy=1, oam_dma=0, mem_rd=0, oam_we=0, mem_addr=0, oam_addr=0, oam_data_out=0, idx=0, page=0, base=0, parity=0.
- A partially written OAM is left as is; no resume.

Cycle counts (all counted in cpu_ce cycles):
- cpu_rdy falls in the first cpu_ce cycle after the trigger.
- cpu_rdy stays low for 513 cycles when parity==0 in HALT, or 514 cycles when parity==1.
- The 513/514 cycles comprise 1 HALT, the optional ALIGN, then 256 READ/WRITE pairs.
- cpu_rdy returns to 1 in the cycle after the final WRITE.

Read latency:
- mem_data_in is sampled in WRITE, exactly one cpu_ce after the matching READ.
- The memory must hold the data stable across any cpu_ce-low gaps.

cpu_ce low:
- State, idx, parity and all outputs hold.
- oam_we is 0.

Sampling:
- oam_start is sampled only at trigger; later changes have no effect on an active transfer.
- A new trigger is accepted in the first IDLE cycle after completion.

## Test plan

- Even parity, page 8'h02, oam_start 0, mem[0x0200+i]=i^8'h5A, cpu_ce always 1 -> cpu_rdy low exactly 513 cycles; OAM[i]=i^8'h5A for all i; 256 oam_we pulses; oam_dma high throughout.
- Trigger on odd parity -> ALIGN entered; cpu_rdy low 514 cycles; data identical to the even case.
- oam_start 8'hF0, page 8'hFF -> first write oam_addr=F0 from mem FF00; write 16 at oam_addr=00; last write EF from FFFF.
- cpu_ce pulsing 1-in-3 -> same OAM contents; cpu_rdy low for 513×3 clk (±2); oam_we high only on ce cycles; no duplicate or missing writes.
- Reset asserted during WRITE at idx=100 -> next clk cpu_rdy=1, oam_dma=0, oam_we=0; a following trigger restarts at idx 0.
- Write to 16'h4015, and a read of 16'h4014 -> no transfer, cpu_rdy stays 1; a second $4014 write during an active DMA -> ignored, page unchanged.
